// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, shared-ALU and response signals for alu_share_arbiter.
// slave is the arbiter's view; master is the requester/ALU/consumer side.
interface alu_share_arbiter_if #(
   parameter int W   = 32,
   parameter int OPW = 4
);
   logic           req0_valid;
   logic           req0_ready;
   logic [W-1:0]   req0_a;
   logic [W-1:0]   req0_b;
   logic [OPW-1:0] req0_op;

   logic           req1_valid;
   logic           req1_ready;
   logic [W-1:0]   req1_a;
   logic [W-1:0]   req1_b;
   logic [OPW-1:0] req1_op;

   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_result;

   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_result;
   logic           rsp_id;

   logic           busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_result, rsp_ready,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_op,
      output rsp_valid, rsp_result, rsp_id, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_result, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_op,
      input  rsp_valid, rsp_result, rsp_id, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters; one op in flight, result returned tagged with the port id.
module alu_share_arbiter #(
   parameter int W   = 32,
   parameter int OPW = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   alu_share_arbiter_if.slave  bus,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         r_state;
   logic           r_last_grant;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [OPW-1:0] r_op;
   logic           r_id;
   logic           r_rsp_valid;
   logic [W-1:0]   r_rsp_result;
   logic           r_rsp_id;

   logic           w_can_accept;
   logic           w_sel1;
   logic           w_accept;
   logic [W-1:0]   w_win_a;
   logic [W-1:0]   w_win_b;
   logic [OPW-1:0] w_win_op;

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1. reqN_ready is combinational and only asserted for the
   // round-robin winner in a cycle where the single op slot is free
   // (IDLE, or RESP with the response retiring). rsp_valid is registered and
   // rsp_result/rsp_id are held until rsp_ready is seen with rsp_valid.
   assign w_can_accept = (r_state == S_IDLE) ||
                         ((r_state == S_RESP) && bus.rsp_ready);
   assign w_sel1       = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
   assign w_accept     = w_can_accept && (bus.req0_valid || bus.req1_valid);

   assign w_win_a  = w_sel1 ? bus.req1_a  : bus.req0_a;
   assign w_win_b  = w_sel1 ? bus.req1_b  : bus.req0_b;
   assign w_win_op = w_sel1 ? bus.req1_op : bus.req0_op;

   // Readies are forced low while reset is held, since the state is
   // already at IDLE then and would otherwise advertise an accept.
   assign bus.req0_ready = reset_n && w_accept && !w_sel1;
   assign bus.req1_ready = reset_n && w_accept &&  w_sel1;

   assign bus.alu_a      = r_a;
   assign bus.alu_b      = r_b;
   assign bus.alu_op     = r_op;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.busy       = (r_state != S_IDLE);
   assign o_dbg_state    = r_state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_id         <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_id     <= 1'b0;
      end else begin
         // Operand regs only move on accept, so the ALU inputs stay quiet
         // outside EXEC.
         if (w_accept) begin
            r_a          <= w_win_a;
            r_b          <= w_win_b;
            r_op         <= w_win_op;
            r_id         <= w_sel1;
            r_last_grant <= w_sel1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_result <= bus.alu_result;
               r_rsp_id     <= r_id;
               r_rsp_valid  <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= w_accept ? S_EXEC : S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   a_one_ready: assert property (@(posedge clk) disable iff (!reset_n)
      !(bus.req0_ready && bus.req1_ready));

   a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
      (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_result) && $stable(bus.rsp_id)));

endmodule
